// File: rtl/mdu_pkg.sv
// Shared MDU opcode encoding and default latencies, imported by the decoder,
// the hazard unit and the MDU itself.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEFAULT = 5;
  localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational multiply/divide datapath. A divide by zero returns the
// current HI/LO so the committed registers are left untouched.
module mdu_alu
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               div_zero;

  assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u   = {32'd0, a} * {32'd0, b};
  // Signed division truncates toward zero; the remainder follows the dividend.
  assign quot_s   = $signed(a) / $signed(b);
  assign rem_s    = $signed(a) % $signed(b);
  assign quot_u   = a / b;
  assign rem_u    = a % b;
  assign div_zero = (b == 32'd0);

  always_comb begin
    hi_res = hi;
    lo_res = lo;
    case (op)
      MD_MULT: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      MD_MULTU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
      end
      MD_DIV: begin
        if (!div_zero) begin
          hi_res = rem_s;
          lo_res = quot_s;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          hi_res = rem_u;
          lo_res = quot_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency sequencing, HI/LO
// ownership and the busy/start handshake seen by the hazard unit.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_tmp_q, hi_tmp_d;
  logic [31:0] lo_tmp_q, lo_tmp_d;
  logic [31:0] hi_res, lo_res;
  logic        idle_ok;

  mdu_alu u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi     (hi_q),
    .lo     (lo_q),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  // Only an unsquashed op seen while idle may change state.
  assign idle_ok = (state_q == StIdle) && !req;
  assign start   = idle_ok && (is_mul(op) || is_div(op));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    if (state_q == StBusy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d    = hi_tmp_q;
        lo_d    = lo_tmp_q;
        state_d = StIdle;
      end
    end else if (start) begin
      state_d  = StBusy;
      cnt_d    = is_mul(op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      hi_tmp_d = hi_res;
      lo_tmp_d = lo_res;
    end else if (idle_ok && op == MD_MTHI) begin
      hi_d = a;
    end else if (idle_ok && op == MD_MTLO) begin
      lo_d = a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  assign busy  = (state_q == StBusy);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = (op == MD_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios then random traffic, all checked
// against a cycle-count reference model built from plain 64-bit arithmetic.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MulN = 5;
  localparam int DivN = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        req;
  logic        start, busy;
  logic [31:0] hi, lo, rdata;

  always #5 clk = ~clk;

  mdu_ctrl #(
    .MULT_CYCLES (MulN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .a     (a),
    .b     (b),
    .req   (req),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: committed HI/LO, result waiting to commit, cycles left.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] o, input logic [31:0] ia, input logic [31:0] ib,
                            input logic ir, input logic irst);
    longint ps, qs, rs;
    longint unsigned pu;
    if (irst) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (!ir) begin
      case (o)
        MD_MULT: begin
          ps = longint'($signed(ia)) * longint'($signed(ib));
          m_phi = ps[63:32]; m_plo = ps[31:0]; m_left = MulN;
        end
        MD_MULTU: begin
          pu = longint'({32'd0, ia}) * longint'({32'd0, ib});
          m_phi = pu[63:32]; m_plo = pu[31:0]; m_left = MulN;
        end
        MD_DIV, MD_DIVU: begin
          m_phi = m_hi; m_plo = m_lo;
          if (ib != 0) begin
            if (o == MD_DIV) begin
              qs = longint'($signed(ia)) / longint'($signed(ib));
              rs = longint'($signed(ia)) - qs * longint'($signed(ib));
            end else begin
              qs = longint'({32'd0, ia}) / longint'({32'd0, ib});
              rs = longint'({32'd0, ia}) % longint'({32'd0, ib});
            end
            m_phi = rs[31:0]; m_plo = qs[31:0];
          end
          m_left = DivN;
        end
        MD_MTHI: m_hi = ia;
        MD_MTLO: m_lo = ia;
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic [3:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ir, input logic irst);
    logic exp_start;
    op = o; a = ia; b = ib; req = ir; reset = irst;
    #3;
    exp_start = (o inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) && !ir && (m_left == 0);
    check_eq("start", {31'd0, start}, {31'd0, exp_start});
    check_eq("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
    check_eq("rdata", rdata, (o == MD_MFHI) ? m_hi : m_lo);
    @(posedge clk);
    model_edge(o, ia, ib, ir, irst);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    op = MD_NONE; a = 0; b = 0; req = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_hi", hi, 32'd0);
    check_eq("reset_lo", lo, 32'd0);

    // MULT -3 * 5
    cycle(MD_NONE, 0, 0, 1'b0, 1'b0);
    cycle(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    idle(MulN);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 2
    cycle(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(MulN);
    check_eq("multu_hi", hi, 32'h0000_0001);
    check_eq("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2, with req raised in busy cycle 3
    cycle(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(2);
    cycle(MD_MTLO, 32'hDEAD_BEEF, 0, 1'b1, 1'b0);
    idle(DivN - 3);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);

    cycle(MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
    idle(DivN);
    check_eq("divu_lo", lo, 32'd3);
    check_eq("divu_hi", hi, 32'd1);

    // MTHI then divide by zero holds HI/LO
    cycle(MD_MTHI, 32'h1234_5678, 0, 1'b0, 1'b0);
    cycle(MD_DIVU, 32'd99, 32'd0, 1'b0, 1'b0);
    idle(DivN);
    cycle(MD_MFHI, 0, 0, 1'b0, 1'b0);
    check_eq("dz_hi", hi, 32'h1234_5678);
    check_eq("dz_lo", lo, 32'd3);

    // Squashed MULT and MTLO
    cycle(MD_MULT, 32'd9, 32'd9, 1'b1, 1'b0);
    cycle(MD_MTLO, 32'hAAAA_5555, 0, 1'b1, 1'b0);
    check_eq("sq_busy", {31'd0, busy}, 32'd0);
    check_eq("sq_lo", lo, 32'd3);

    // Reset in busy cycle 4 of a DIV, then a normal MULT
    cycle(MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(3);
    cycle(MD_NONE, 0, 0, 1'b0, 1'b1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    idle(DivN);
    check_eq("rst_nocommit", lo, 32'd0);
    cycle(MD_MULT, 32'd6, 32'd7, 1'b0, 1'b0);
    idle(MulN);
    check_eq("post_rst_mult", lo, 32'd42);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r_op = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) r_op = 4'hF;
      r_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      r_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      if ($urandom_range(0, 7) == 0) r_b = 32'd0;
      if (r_op == MD_DIV && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) r_b = 32'd3;
      cycle(r_op, r_a, r_b, $urandom_range(0, 7) == 0, $urandom_range(0, 60) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
